// File: rtl/matrixmultiplicationkernel_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : matrixmultiplicationkernel_mac_pipe
// Description : Pipelined multiply-accumulate with per-operand signedness,
//               first/last group framing and sticky signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module matrixmultiplicationkernel_mac_pipe #(
   parameter int DIN0_WIDTH  = 24,
   parameter int DIN1_WIDTH  = 24,
   parameter int ACC_WIDTH   = 64,
   parameter int NUM_STAGE   = 4,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [ACC_WIDTH-1:0]  dout,
   output logic                  dout_ovf
);

   localparam int c_AW = DIN0_WIDTH + 1;
   localparam int c_BW = DIN1_WIDTH + 1;
   localparam int c_PW = DIN0_WIDTH + DIN1_WIDTH + 1;
   // Bits above ACC_WIDTH would be discarded by the accumulator anyway
   localparam int c_SW = (ACC_WIDTH < c_PW) ? ACC_WIDTH : c_PW;
   localparam int c_NP = NUM_STAGE - 1;

   logic [c_AW-1:0]      a_q, a_d;
   logic [c_BW-1:0]      b_q, b_d;
   logic                 v1_q, f1_q, l1_q;
   logic [c_SW-1:0]      mul_a, mul_b, prod_d;
   logic [c_SW-1:0]      prod_q [c_NP];
   logic [c_NP-1:0]      pv_q, pf_q, pl_q;

   logic [ACC_WIDTH-1:0] p_acc, sum, acc_q, acc_d, dout_q;
   logic                 ovf_q, ovf_d, ovf_add, lst_q, lst_d;
   logic                 out_valid_q, dout_ovf_q;

   assign a_d = (DIN0_SIGNED != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
   assign b_d = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};

   // Low bits of a two's-complement product do not depend on signedness
   assign mul_a  = {{(c_SW-c_AW){a_q[c_AW-1]}}, a_q};
   assign mul_b  = {{(c_SW-c_BW){b_q[c_BW-1]}}, b_q};
   assign prod_d = mul_a * mul_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         v1_q <= 1'b0;
         f1_q <= 1'b0;
         l1_q <= 1'b0;
         pv_q <= '0;
         pf_q <= '0;
         pl_q <= '0;
      end else if (ce) begin
         v1_q     <= in_valid;
         f1_q     <= in_first;
         l1_q     <= in_last;
         pv_q[0]  <= v1_q;
         pf_q[0]  <= f1_q;
         pl_q[0]  <= l1_q;
         for (int i = 1; i < c_NP; i++) begin
            pv_q[i] <= pv_q[i-1];
            pf_q[i] <= pf_q[i-1];
            pl_q[i] <= pl_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         a_q       <= a_d;
         b_q       <= b_d;
         prod_q[0] <= prod_d;
         for (int i = 1; i < c_NP; i++) begin
            prod_q[i] <= prod_q[i-1];
         end
      end
   end

   generate
      if (ACC_WIDTH > c_SW) begin : g_sext
         assign p_acc = {{(ACC_WIDTH-c_SW){prod_q[c_NP-1][c_SW-1]}}, prod_q[c_NP-1]};
      end else begin : g_direct
         assign p_acc = prod_q[c_NP-1];
      end
   endgenerate

   assign sum     = acc_q + p_acc;
   assign ovf_add = (acc_q[ACC_WIDTH-1] == p_acc[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      lst_d = pv_q[c_NP-1] & pl_q[c_NP-1];
      if (pv_q[c_NP-1]) begin
         if (pf_q[c_NP-1]) begin
            acc_d = p_acc;
            ovf_d = 1'b0;
         end else begin
            acc_d = sum;
            ovf_d = ovf_q | ovf_add;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         lst_q       <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         dout_ovf_q  <= 1'b0;
      end else if (ce) begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         lst_q       <= lst_d;
         out_valid_q <= lst_q;
         if (lst_q) begin
            dout_q     <= acc_q;
            dout_ovf_q <= ovf_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign dout_ovf  = dout_ovf_q;

endmodule
`default_nettype wire
